// File: rtl/sonar_frame_uc.sv
// Sonar sweep control unit: position wait, measurement, serial frame, servo step.
// Define SONAR_BOUNCE_SWEEP_EN for a back-and-forth sweep instead of wrap-around.
module sonar_frame_uc #(
   parameter int N_CAMPOS       = 8,
   parameter int SEL_W          = 3,
   parameter int N_POSICOES     = 8,
   parameter int POS_W          = 3,
   parameter int TIMEOUT_CICLOS = 1024
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ligar,
   input  logic             modo,
   input  logic             medir,
   input  logic             pronto_medida,
   input  logic             fim_timer,
   input  logic             pronto_serial,
   output logic             partida_serial,
   output logic             zera_timer,
   output logic             conta_timer,
   output logic             reset_servo,
   output logic [SEL_W-1:0] sel_letra,
   output logic [POS_W-1:0] posicao,
   output logic             sentido,
   output logic             fim_frame,
   output logic             erro_timeout,
   output logic [3:0]       db_estado
);

   localparam int CNT_W = $clog2(TIMEOUT_CICLOS);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_CAMPOS - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_POSICOES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CICLOS - 1);

   typedef enum logic [3:0] {
      INICIAL    = 4'h0,
      PREPARACAO = 4'h1,
      ESPERA     = 4'h2,
      AGUARDA    = 4'h3,
      TRANSMITE  = 4'h4,
      ESPERA_TX  = 4'h5,
      PROXIMO    = 4'h6,
      ATUALIZA   = 4'h7,
      TIMEOUT    = 4'hF
   } estado_t;

   estado_t          state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             sen_q, sen_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic             erro_q, erro_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             partida_q, partida_d;
   logic             zera_q, zera_d;
   logic             conta_q, conta_d;
   logic             rservo_q, rservo_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             fim_q, fim_d;

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      sen_d   = sen_q;
      idx_d   = idx_q;
      erro_d  = erro_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         INICIAL: begin
            if (ligar) state_d = PREPARACAO;
         end
         PREPARACAO: begin
            pos_d   = '0;
            sen_d   = 1'b0;
            idx_d   = '0;
            erro_d  = 1'b0;
            state_d = ESPERA;
         end
         ESPERA: begin
            cnt_d = '0;
            if (!ligar) state_d = INICIAL;
            else if (modo ? medir : fim_timer) state_d = AGUARDA;
         end
         AGUARDA: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (pronto_medida) begin
               idx_d   = '0;
               state_d = TRANSMITE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = TIMEOUT;
            end
         end
         TRANSMITE: state_d = ESPERA_TX;
         ESPERA_TX: begin
            if (pronto_serial)
               state_d = (idx_q == IDX_LAST) ? ATUALIZA : PROXIMO;
         end
         PROXIMO: begin
            idx_d   = idx_q + SEL_W'(1);
            state_d = TRANSMITE;
         end
         ATUALIZA: begin
            state_d = ESPERA;
`ifdef SONAR_BOUNCE_SWEEP_EN
            if (N_POSICOES == 1) begin
               pos_d = '0;
               sen_d = 1'b0;
            end else if (!sen_q) begin
               if (pos_q == POS_LAST) begin
                  sen_d = 1'b1;
                  pos_d = pos_q - POS_W'(1);
               end else begin
                  pos_d = pos_q + POS_W'(1);
               end
            end else if (pos_q == '0) begin
               sen_d = 1'b0;
               pos_d = POS_W'(1);
            end else begin
               pos_d = pos_q - POS_W'(1);
            end
`else
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
            sen_d = 1'b0;
`endif
         end
         TIMEOUT: begin
            erro_d  = 1'b1;
            state_d = ESPERA;
         end
         default: state_d = INICIAL;
      endcase

      // Outputs decoded from the next state so the registered copy is Moore-aligned
      partida_d = (state_d == TRANSMITE);
      zera_d    = (state_d == PREPARACAO) || (state_d == ATUALIZA) ||
                  (state_d == TIMEOUT);
      conta_d   = (state_d == ESPERA) && !modo;
      rservo_d  = (state_d == PREPARACAO);
      fim_d     = (state_d == ATUALIZA);
      sel_d     = ((state_d == TRANSMITE) || (state_d == ESPERA_TX) ||
                   (state_d == PROXIMO)) ? idx_d : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= INICIAL;
         pos_q     <= '0;
         sen_q     <= 1'b0;
         idx_q     <= '0;
         erro_q    <= 1'b0;
         cnt_q     <= '0;
         partida_q <= 1'b0;
         zera_q    <= 1'b0;
         conta_q   <= 1'b0;
         rservo_q  <= 1'b0;
         sel_q     <= '0;
         fim_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         sen_q     <= sen_d;
         idx_q     <= idx_d;
         erro_q    <= erro_d;
         cnt_q     <= cnt_d;
         partida_q <= partida_d;
         zera_q    <= zera_d;
         conta_q   <= conta_d;
         rservo_q  <= rservo_d;
         sel_q     <= sel_d;
         fim_q     <= fim_d;
      end
   end

   assign partida_serial = partida_q;
   assign zera_timer     = zera_q;
   assign conta_timer    = conta_q;
   assign reset_servo    = rservo_q;
   assign sel_letra      = sel_q;
   assign posicao        = pos_q;
   assign sentido        = sen_q;
   assign fim_frame      = fim_q;
   assign erro_timeout   = erro_q;
   assign db_estado      = state_q;

endmodule

// File: tb/tb_sonar_frame_uc.sv
// Directed bench for sonar_frame_uc: frames, sweep, timeout, single-shot, abort.
// Sweep expectations follow SONAR_BOUNCE_SWEEP_EN when it is defined.
module tb_sonar_frame_uc;

   logic       clock = 1'b0;
   logic       reset;
   logic       ligar, modo, medir;
   logic       pronto_medida, fim_timer, pronto_serial;
   logic       partida_serial, zera_timer, conta_timer, reset_servo;
   logic [2:0] sel_letra;
   logic [1:0] posicao;
   logic       sentido, fim_frame, erro_timeout;
   logic [3:0] db_estado;

   int n_chk = 0;
   int n_err = 0;

   sonar_frame_uc #(
      .N_CAMPOS(8), .SEL_W(3), .N_POSICOES(4), .POS_W(2),
      .TIMEOUT_CICLOS(16)
   ) dut (
      .clock(clock), .reset(reset), .ligar(ligar), .modo(modo),
      .medir(medir), .pronto_medida(pronto_medida),
      .fim_timer(fim_timer), .pronto_serial(pronto_serial),
      .partida_serial(partida_serial), .zera_timer(zera_timer),
      .conta_timer(conta_timer), .reset_servo(reset_servo),
      .sel_letra(sel_letra), .posicao(posicao), .sentido(sentido),
      .fim_frame(fim_frame), .erro_timeout(erro_timeout),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

`ifdef SONAR_BOUNCE_SWEEP_EN
   int tbl_pos [9] = '{1, 2, 3, 2, 1, 0, 1, 2, 3};
   int tbl_sen [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
   localparam int RETRY_SEN = 1;
`else
   int tbl_pos [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
   int tbl_sen [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
   localparam int RETRY_SEN = 0;
`endif

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // From espera: trigger a measurement and land in transmite
   task automatic start_frame();
      if (modo) medir = 1'b1;
      else fim_timer = 1'b1;
      tick();
      medir = 1'b0;
      fim_timer = 1'b0;
      chk("aguarda", db_estado, 4'd3);
      pronto_medida = 1'b1;
      tick();
      pronto_medida = 1'b0;
   endtask

   // Serve characters (pronto_serial 3 cycles after each partida)
   task automatic serve_frame(input int drop_at, input int stop_at,
                              input int exp_pos, input int exp_sen,
                              output bit hit);
      int np, nf, cd;
      bit ord;
      np = 0; nf = 0; cd = 0; ord = 1'b1; hit = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (partida_serial) begin
            if (int'(sel_letra) != np) ord = 1'b0;
            if (int'(sel_letra) == stop_at) begin
               hit = 1'b1;
               pronto_serial = 1'b0;
               return;
            end
            if (int'(sel_letra) == drop_at) ligar = 1'b0;
            np++;
            cd = 3;
         end
         if (fim_frame) nf++;
         if (nf == 1 && db_estado == 4'd2) break;
         pronto_serial = (cd == 1);
         if (cd > 0) cd--;
         tick();
      end
      pronto_serial = 1'b0;
      if (stop_at < 0) begin
         chk("n_partida", np, 8);
         chk("sel_order", ord, 1);
         chk("n_fim_frame", nf, 1);
         chk("end_espera", db_estado, 4'd2);
         chk("posicao", posicao, exp_pos);
         chk("sentido", sentido, exp_sen);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      int n;
      reset = 1'b1; ligar = 1'b0; modo = 1'b0; medir = 1'b0;
      pronto_medida = 1'b0; fim_timer = 1'b0; pronto_serial = 1'b0;
      tick();
      tick();
      chk("rst_estado", db_estado, 4'd0);
      chk("rst_sel", sel_letra, 0);
      chk("rst_pos", posicao, 0);
      chk("rst_erro", erro_timeout, 0);
      chk("rst_pulses", {partida_serial, fim_frame, zera_timer,
                         reset_servo, conta_timer, sentido}, 0);
      reset = 1'b0;
      tick();
      chk("idle_inicial", db_estado, 4'd0);
      ligar = 1'b1;
      tick();
      chk("prep_estado", db_estado, 4'd1);
      chk("prep_outs", {zera_timer, reset_servo}, 2'b11);
      tick();
      chk("espera_estado", db_estado, 4'd2);
      chk("espera_conta", conta_timer, 1);

      for (int f = 0; f < 9; f++) begin
         start_frame();
         chk("first_sel", sel_letra, 0);
         serve_frame(-1, -1, tbl_pos[f], tbl_sen[f], hit);
      end

      // Timeout: 16 cycles in aguarda_medida
      fim_timer = 1'b1;
      tick();
      fim_timer = 1'b0;
      n = 0;
      while (db_estado == 4'd3 && n < 40) begin
         tick();
         n++;
      end
      chk("to_cycles", n, 16);
      chk("to_estado", db_estado, 4'hF);
      chk("to_zera", zera_timer, 1);
      tick();
      chk("to_back", db_estado, 4'd2);
      chk("to_erro", erro_timeout, 1);
      chk("to_pos", posicao, tbl_pos[8]);
      start_frame();
      serve_frame(-1, -1, 2, RETRY_SEN, hit);
      chk("erro_held", erro_timeout, 1);

      // Re-arm through preparacao clears the flag
      ligar = 1'b0;
      tick();
      chk("off_inicial", db_estado, 4'd0);
      ligar = 1'b1;
      tick();
      tick();
      chk("clr_erro", erro_timeout, 0);
      chk("clr_pos", {posicao, sentido}, 0);

      // Tie: pronto_medida with counter at 15
      fim_timer = 1'b1;
      tick();
      fim_timer = 1'b0;
      repeat (15) tick();
      pronto_medida = 1'b1;
      tick();
      pronto_medida = 1'b0;
      chk("tie_estado", db_estado, 4'd4);
      chk("tie_erro", erro_timeout, 0);
      serve_frame(-1, -1, 1, 0, hit);

      // Single-shot
      modo = 1'b1;
      tick();
      chk("ss_conta", conta_timer, 0);
      fim_timer = 1'b1;
      repeat (3) tick();
      fim_timer = 1'b0;
      chk("ss_ignore", db_estado, 4'd2);
      start_frame();
      serve_frame(-1, -1, 2, 0, hit);
      repeat (10) tick();
      chk("ss_idle", db_estado, 4'd2);
      chk("ss_pos", posicao, 2);

      // ligar dropped at idx 3: frame still completes
      modo = 1'b0;
      start_frame();
      serve_frame(3, -1, 3, 0, hit);
      tick();
      chk("drop_inicial", db_estado, 4'd0);

      // Async reset at idx 5
      ligar = 1'b1;
      tick();
      tick();
      start_frame();
      serve_frame(-1, 5, 0, 0, hit);
      chk("hit5", hit, 1);
      chk("pre_rst", {partida_serial, sel_letra}, 4'b1101);
      #1 reset = 1'b1;
      #1;
      chk("arst_estado", db_estado, 4'd0);
      chk("arst_outs", {partida_serial, sel_letra, posicao,
                        erro_timeout, fim_frame}, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst", db_estado, 4'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sonar_frame_uc.md
Name: sonar_frame_uc

Overview:
- Parametrised control unit for the sonar sweep.
- Sequences position wait, measurement capture and a serial frame of N_CAMPOS characters, then advances an internal servo position index.
- Adds single-shot mode, a measurement timeout and a configurable sweep.
- Sits between the servo/timer/measurement datapath and the character mux feeding the serial TX.

Parameters:
- N_CAMPOS, 8, characters per serial frame (>=1).
- SEL_W, 3, width of sel_letra; 2^SEL_W >= N_CAMPOS.
- N_POSICOES, 8, servo positions per sweep (>=1).
- POS_W, 3, width of posicao; 2^POS_W >= N_POSICOES.
- TIMEOUT_CICLOS, 1024, max cycles spent in aguarda_medida (>=2).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ligar  in  1  enable level
- modo  in  1  0 = continuous (timer paced), 1 = single-shot (medir paced)
- medir  in  1  single-shot trigger, sampled only in espera with modo=1
- pronto_medida  in  1  measurement done pulse
- fim_timer  in  1  position dwell timer expired
- pronto_serial  in  1  serial TX finished character
- partida_serial  out  1  one-cycle TX start
- zera_timer  out  1  clear dwell timer
- conta_timer  out  1  dwell timer enable
- reset_servo  out  1  servo reset
- sel_letra  out  SEL_W  character index for frame mux
- posicao  out  POS_W  current servo position
- sentido  out  1  sweep direction, 0 = up, 1 = down
- fim_frame  out  1  one-cycle pulse, frame complete
- erro_timeout  out  1  sticky measurement-timeout flag
- db_estado  out  4  state code for debug display

Behaviour:
- Reset (async) state: inicial. All pulse outputs 0, sel_letra=0, posicao=0, sentido=0, erro_timeout=0, internal idx and timeout counter 0.
- Moore outputs throughout; registered regs (posicao, sentido, idx, erro_timeout, timeout counter) update on clock edge.
- State codes: inicial 0, preparacao 1, espera 2, aguarda_medida 3, transmite 4, espera_tx 5, proximo_campo 6, atualiza_posicao 7, timeout F.
- inicial: ligar=1 -> preparacao; otherwise stay.
- preparacao (1 cycle):
  - zera_timer=1, reset_servo=1.
  - posicao<=0, sentido<=0, idx<=0, erro_timeout<=0.
  - -> espera.
- espera:
  - ligar=0 -> inicial; this has highest priority.
  - modo=0: conta_timer=1; fim_timer -> aguarda_medida.
  - modo=1: conta_timer=0; medir -> aguarda_medida; fim_timer is ignored.
  - On exit, clear the timeout counter.
- aguarda_medida:
  - The counter increments each cycle.
  - pronto_medida -> transmite, with idx<=0.
  - Else counter==TIMEOUT_CICLOS-1 -> timeout.
  - If both occur in the same cycle, pronto_medida wins.
- transmite: partida_serial=1 for exactly 1 cycle -> espera_tx.
- espera_tx: wait for pronto_serial.
  - idx==N_CAMPOS-1 -> atualiza_posicao.
  - Otherwise -> proximo_campo.
- proximo_campo: idx<=idx+1 -> transmite.
- sel_letra=idx in transmite, espera_tx and proximo_campo; 0 elsewhere.
- atualiza_posicao (1 cycle): fim_frame=1, zera_timer=1, advance posicao per sweep rule -> espera.
- timeout (1 cycle): erro_timeout<=1, zera_timer=1 -> espera. No frame is sent, posicao is unchanged, and the measurement is retried.
- ligar is ignored outside inicial and espera: an in-progress frame always completes.
- Sweep rule, default (wrap): posicao<=(posicao==N_POSICOES-1)?0:posicao+1; sentido stays 0.
- N_POSICOES=1: posicao stays 0.
- Reset asserted mid-frame: immediate return to inicial and all reset values.

Optional Feature:
- Macro: SONAR_BOUNCE_SWEEP_EN.
- Defined: bounce sweep.
  - sentido=0: at N_POSICOES-1 set sentido<=1 and posicao<=posicao-1; else increment.
  - sentido=1: at 0 set sentido<=0 and posicao<=1; else decrement.
  - N_POSICOES=1 holds 0.
  - Sequence for N_POSICOES=4: 0,1,2,3,2,1,0,1...
- Undefined: wrap rule above; sentido tied to 0.

Test Plan:
- Continuous frame (N_CAMPOS=8, modo=0), ligar=1, fim_timer, pronto_medida, pronto_serial 3 cycles after each partida -> exactly 8 partida_serial pulses with sel_letra 0..7 in order, one fim_frame, posicao 0->1.
- Sweep (N_POSICOES=4), 9 consecutive frames -> posicao after each: 1,2,3,0,1,2,3,0,1 without macro; 1,2,3,2,1,0,1,2,3 with SONAR_BOUNCE_SWEEP_EN (sentido 1 during descent).
- Timeout (TIMEOUT_CICLOS=16), enter aguarda_medida, no pronto_medida -> timeout state after 16 cycles, erro_timeout=1 held, posicao unchanged, back in espera; next preparacao clears it.
- Tie: pronto_medida in the cycle the counter hits 15 -> transmite, erro_timeout stays 0.
- Single-shot (modo=1), fim_timer pulses ignored, conta_timer=0; medir pulse -> one full frame, then idle in espera.
- ligar dropped mid-frame at idx=3 -> frame finishes (idx 4..7 sent), fim_frame, then espera -> inicial; async reset at idx=5 -> db_estado=0, all outputs reset immediately.
